// File: rtl/udiv_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first,
// with a valid/ready request side and a valid/ready result side.
module udiv_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_dvs_zero;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH:0]   w_quo_ext;
  logic [WIDTH:0]   w_dvd_ext;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_dvd_nxt;

  // Handshake qualifiers
  always_comb begin
    w_accept   = in_valid & in_ready;
    w_dvs_zero = (divisor == {WIDTH{1'b0}});
    w_last     = (r_cnt == CW'(1));
  end

  // One restoring-division step; the remainder carries an extra bit so the
  // shifted value never overflows before the compare.
  always_comb begin
    w_shift   = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_ge      = (w_shift >= {1'b0, r_dvs});
    w_quo_ext = {r_quo, w_ge};
    w_dvd_ext = {r_dvd, 1'b0};
    w_quo_nxt = w_quo_ext[WIDTH-1:0];
    w_dvd_nxt = w_dvd_ext[WIDTH-1:0];
    if (w_ge) begin
      w_rem_nxt = w_diff;
    end else begin
      w_rem_nxt = w_shift;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake outputs decoded from the registered state
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) begin
          if (w_dvs_zero) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_dvd       <= {WIDTH{1'b0}};
      r_dvs       <= {WIDTH{1'b0}};
      r_rem       <= {(WIDTH + 1){1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_rem <= {(WIDTH + 1){1'b0}};
            r_quo <= {WIDTH{1'b0}};
            if (w_dvs_zero) begin
              r_cnt       <= {CW{1'b0}};
              r_quotient  <= {WIDTH{1'b1}};
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_cnt <= CW'(WIDTH);
            end
          end
        end
        ST_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_dvd <= w_dvd_nxt;
          r_cnt <= r_cnt - CW'(1);
          // The last step publishes straight from the step logic
          if (w_last) begin
            r_quotient  <= w_quo_nxt;
            r_remainder <= w_rem_nxt[WIDTH-1:0];
            r_dbz       <= 1'b0;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_udiv_seq.sv
// Directed self-checking bench for udiv_seq at WIDTH=8 and WIDTH=1.
module tb_udiv_seq;

  logic       CLK;
  logic       ASYNCRESETN;
  logic       in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [7:0] dividend, divisor, quotient, remainder;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, dbz1;
  logic [0:0] dividend1, divisor1, quotient1, remainder1;

  int n_tests;
  int n_fail;

  udiv_seq #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  udiv_seq #(.WIDTH(1)) u_dut1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .dividend(dividend1), .divisor(divisor1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .quotient(quotient1), .remainder(remainder1), .div_by_zero(dbz1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a request on the next negedge; return #1 after the accept edge
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Latency counts the accept edge as edge 1
  task automatic await8(input string tag, input logic [7:0] eq, input logic [7:0] er,
                        input logic ez, input int elat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"}, {24'd0, quotient}, {24'd0, eq});
    chk({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
    chk({tag, "_z"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  task automatic release8(input string tag, input logic [7:0] eq);
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_q_hold"}, {24'd0, quotient}, {24'd0, eq});
  endtask

  task automatic div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input logic ez, input int elat);
    launch8(a, b);
    await8(tag, eq, er, ez, elat);
    release8(tag, eq);
  endtask

  initial begin
    logic [0:0] a1, b1;
    logic [0:0] eq1, er1;
    int lat;
    int spurious;
    n_tests     = 0;
    n_fail      = 0;
    ASYNCRESETN = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    dividend    = 8'd0;
    divisor     = 8'd0;
    in_valid1   = 1'b0;
    out_ready1  = 1'b0;
    dividend1   = 1'b0;
    divisor1    = 1'b0;
    #23;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", {24'd0, quotient}, 32'd0);
    chk("rst_r", {24'd0, remainder}, 32'd0);
    chk("rst_z", {31'd0, div_by_zero}, 32'd0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    div8("basic", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    div8("dbz", 8'd55, 8'd0, 8'd255, 8'd55, 1'b1, 1);
    div8("by1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    div8("small", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 9);
    div8("same", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
    div8("odd", 8'd129, 8'd16, 8'd8, 8'd1, 1'b0, 9);

    // Backpressure: result held while inputs churn
    launch8(8'd200, 8'd13);
    await8("bp", 8'd15, 8'd5, 1'b0, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      in_valid = ~in_valid;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      @(posedge CLK);
      #1;
      chk("bp_q_stable", {24'd0, quotient}, 32'd15);
      chk("bp_r_stable", {24'd0, remainder}, 32'd5);
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge CLK);
    in_valid  = 1'b1;
    dividend  = 8'd50;
    divisor   = 8'd5;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk("bp_rdy_after", {31'd0, in_ready}, 32'd1);
    chk("bp_q_after", {24'd0, quotient}, 32'd15);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    await8("bp_next", 8'd10, 8'd0, 1'b0, 9);
    release8("bp_next", 8'd10);

    // Reset in the third BUSY cycle
    launch8(8'd100, 8'd7);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("mrst_q", {24'd0, quotient}, 32'd0);
    chk("mrst_r", {24'd0, remainder}, 32'd0);
    chk("mrst_z", {31'd0, div_by_zero}, 32'd0);
    chk("mrst_ov", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #1;
      if (out_valid) spurious++;
    end
    chk("mrst_spurious", 32'(spurious), 32'd0);
    chk("mrst_in_ready_rel", {31'd0, in_ready}, 32'd1);
    div8("post_rst", 8'd77, 8'd9, 8'd8, 8'd5, 1'b0, 9);

    // WIDTH=1 exhaustive
    for (int k = 0; k < 4; k++) begin
      a1 = 1'(k >> 1);
      b1 = 1'(k);
      if (b1 == 1'b0) begin
        eq1 = 1'b1;
        er1 = a1;
      end else begin
        eq1 = a1;
        er1 = 1'b0;
      end
      @(negedge CLK);
      in_valid1 = 1'b1;
      dividend1 = a1;
      divisor1  = b1;
      @(posedge CLK);
      #1;
      in_valid1 = 1'b0;
      dividend1 = ~a1;
      divisor1  = ~b1;
      lat = 1;
      while (!out_valid1 && lat < 10) begin
        @(posedge CLK);
        #1;
        lat++;
      end
      chk("w1_lat", 32'(lat), (b1 == 1'b0) ? 32'd1 : 32'd2);
      chk("w1_q", {31'd0, quotient1}, {31'd0, eq1});
      chk("w1_r", {31'd0, remainder1}, {31'd0, er1});
      chk("w1_z", {31'd0, dbz1}, {31'd0, ~b1});
      @(negedge CLK);
      out_ready1 = 1'b1;
      @(posedge CLK);
      #1;
      out_ready1 = 1'b0;
      chk("w1_rdy_after", {31'd0, in_ready1}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
